serial_hba_bridge: RTL and testbench

Second-generation serial-to-HBA bridge. It wraps the existing buart core and adds a framed command protocol. The protocol supports burst reads and writes with register auto-increment, RTS/CTS flow control and an error interrupt, so an external host (e.g. a Raspberry Pi) can act as master on the HBA bus. The block sits at the top level between the serial pins and the HBA master port.

---
 rtl/serial_hba_pkg.sv | 16 +
 rtl/serial_hba_bridge_buart.sv | 94 +++++++++
 rtl/serial_hba_bridge.sv | 153 +++++++++++++++
 tb/tb_serial_hba_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_hba_pkg.sv
// Shared types and constants for the serial-to-HBA bridge.
package serial_hba_pkg;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_REQ, BUS_WAIT, TX_LOAD, TX_WAIT
  } state_t;

  localparam int RNW_BIT    = 7;
  localparam int LEN_MSB    = 6;
  localparam int LEN_LSB    = 4;
  localparam int PERIPH_MSB = 3;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/serial_hba_bridge_buart.sv
// Byte UART: 8N1, one-byte receive holding register with valid/rd, transmit with wr/busy.
module buart #(
  parameter int CLKFREQ = 100_000_000,
  parameter int BAUD    = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       valid,
  input  logic       rd,
  input  logic [7:0] tx_data,
  input  logic       wr,
  output logic       busy
);
  localparam int DIV = CLKFREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);

  logic [1:0]    rx_sync;
  logic          rx_act;
  logic [3:0]    rx_bit;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_sh;
  logic [9:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  // Receiver samples mid-bit; a byte arriving while one is still held is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_act  <= 1'b0;
      rx_bit  <= '0;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      valid   <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (rd) valid <= 1'b0;
      if (!rx_act) begin
        if (!rx_sync[1]) begin
          rx_act <= 1'b1;
          rx_bit <= '0;
          rx_cnt <= CW'(DIV / 2 - 1);
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= CW'(DIV - 1);
        if (rx_bit == 4'd0 && rx_sync[1]) begin
          rx_act <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          if (rx_sync[1] && (!valid || rd)) begin
            rx_data <= rx_sh;
            valid   <= 1'b1;
          end
        end else begin
          if (rx_bit != 4'd0) rx_sh <= {rx_sync[1], rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sh  <= '1;
      tx_bit <= '0;
      tx_cnt <= '0;
      busy   <= 1'b0;
    end else if (!busy) begin
      if (wr) begin
        tx_sh  <= {1'b1, tx_data, 1'b0};
        tx_bit <= 4'd9;
        tx_cnt <= CW'(DIV - 1);
        busy   <= 1'b1;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else if (tx_bit == 4'd0) begin
      busy <= 1'b0;
    end else begin
      tx_sh  <= {1'b1, tx_sh[9:1]};
      tx_bit <= tx_bit - 4'd1;
      tx_cnt <= CW'(DIV - 1);
    end
  end

  assign tx = tx_sh[0];

endmodule

// File: rtl/serial_hba_bridge.sv
// Framed serial command bridge acting as HBA bus master over a buart link.
// Optional bus watchdog enabled by defining SERIAL_HBA_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for CMD byte
// GET_ADDR | waiting for start register byte
// GET_DATA | waiting for write data byte (or discarding after timeout)
// BUS_REQ  | raise bus request
// BUS_WAIT | request held until xferack (or watchdog)
// TX_LOAD  | wait for rts and idle transmitter, then load reply byte
// TX_WAIT  | reply byte shifting out
module serial_hba_bridge
  import serial_hba_pkg::*;
#(
  parameter int CLK_FREQUENCY  = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  rxd,
  input  logic                  rts,
  output logic                  txd,
  output logic                  cts,
  output logic                  intr,
  input  logic                  hba_mgrant,
  input  logic                  hba_xferack,
  input  logic [7:0]            hba_dbus,
  output logic                  masterx_request,
  output logic [ADDR_WIDTH-1:0] master_abus,
  output logic                  master_rnw,
  output logic [7:0]            master_dbus
);
  localparam int RW = ADDR_WIDTH - 4;

  state_t        state, next;
  logic [7:0]    rx_data, tx_byte, wdata;
  logic          valid, busy, rd, wr, ready, accepting;
  logic          rnw, req, err, timed_out, bus_on;
  logic [3:0]    periph;
  logic [RW-1:0] reg_addr;
  logic [2:0]    remaining;

  buart #(.CLKFREQ(CLK_FREQUENCY), .BAUD(BAUD)) u_buart (
    .clk(hba_clk), .reset(hba_reset), .rx(rxd), .tx(txd),
    .rx_data(rx_data), .valid(valid), .rd(rd),
    .tx_data(tx_byte), .wr(wr), .busy(busy)
  );

  assign accepting = ready && (state == IDLE || state == GET_ADDR || state == GET_DATA);
  assign cts       = accepting;
  assign rd        = accepting && valid;
  assign wr        = (state == TX_LOAD) && rts && !busy;

  assign bus_on          = req && hba_mgrant;
  assign masterx_request = req;
  assign master_abus     = bus_on ? {periph, reg_addr} : '0;
  assign master_rnw      = bus_on && rnw;
  assign master_dbus     = (bus_on && !rnw) ? wdata : '0;

`ifdef SERIAL_HBA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          intr_q;

  // Down-counter reloads whenever outside BUS_WAIT, so it restarts on every entry.
  always_ff @(posedge hba_clk) begin
    if (hba_reset || state != BUS_WAIT) tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (tmo_cnt != '0)             tmo_cnt <= tmo_cnt - 1'b1;
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset)                   intr_q <= 1'b0;
    else if (state == IDLE && rd)    intr_q <= 1'b0;
    else if (timed_out)              intr_q <= 1'b1;
  end

  assign timed_out = (state == BUS_WAIT) && !hba_xferack && (tmo_cnt == '0);
  assign intr      = intr_q;
`else
  assign timed_out = 1'b0;
  assign intr      = 1'b0;
`endif

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      state <= next;
      ready <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:     if (rd) next = GET_ADDR;
      GET_ADDR: if (rd) next = rnw ? BUS_REQ : GET_DATA;
      GET_DATA: if (rd) next = !err ? BUS_REQ : (remaining == 3'd0 ? TX_LOAD : GET_DATA);
      BUS_REQ:  next = BUS_WAIT;
      BUS_WAIT: if (hba_xferack || timed_out)
                  next = (!rnw && remaining != 3'd0) ? GET_DATA : TX_LOAD;
      TX_LOAD:  if (wr) next = TX_WAIT;
      TX_WAIT:  if (!busy) next = (rnw && !err && remaining != 3'd0) ? BUS_REQ : IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      req       <= 1'b0;
      err       <= 1'b0;
      rnw       <= 1'b0;
      periph    <= '0;
      reg_addr  <= '0;
      remaining <= '0;
      wdata     <= '0;
      tx_byte   <= '0;
    end else begin
      case (state)
        IDLE: if (rd) begin
          rnw       <= rx_data[RNW_BIT];
          remaining <= rx_data[LEN_MSB:LEN_LSB];
          periph    <= rx_data[PERIPH_MSB:0];
          err       <= 1'b0;
        end
        GET_ADDR: if (rd) reg_addr <= rx_data[RW-1:0];
        GET_DATA: if (rd) begin
          wdata <= rx_data;
          if (err) begin
            if (remaining == 3'd0) tx_byte   <= ERR_BYTE;
            else                   remaining <= remaining - 3'd1;
          end
        end
        BUS_REQ: req <= 1'b1;
        BUS_WAIT: if (hba_xferack || timed_out) begin
          req <= 1'b0;
          if (hba_xferack) reg_addr <= reg_addr + 1'b1;
          if (timed_out)   err      <= 1'b1;
          // A read that times out ends the burst here.
          if (timed_out && rnw)                remaining <= '0;
          else if (!rnw && remaining != 3'd0)  remaining <= remaining - 3'd1;
          tx_byte <= timed_out ? ERR_BYTE : (rnw ? hba_dbus : ACK_BYTE);
        end
        TX_WAIT: if (!busy && rnw && !err && remaining != 3'd0) remaining <= remaining - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_hba_bridge.sv
// Directed scoreboard bench for serial_hba_bridge: host UART driver, HBA slave model, TX monitor.
module tb_serial_hba_bridge;
  localparam int CLK_HZ = 1_843_200;
  localparam int BAUD   = 115_200;
  localparam int DIV    = CLK_HZ / BAUD;

  typedef struct packed {
    logic        rnw;
    logic [11:0] abus;
    logic [7:0]  dbus;
  } bus_t;

  logic        hba_clk = 1'b0;
  logic        hba_reset, rxd, rts, hba_mgrant, hba_xferack;
  logic [7:0]  hba_dbus;
  logic        txd, cts, intr, masterx_request, master_rnw;
  logic [11:0] master_abus;
  logic [7:0]  master_dbus;

  int vecs = 0;
  int errs = 0;
  int grant_dly = 1;
  int hang = 0;
  int tx_count = 0;

  bus_t       exp_bus[$];
  logic [7:0] rd_q[$];
  logic [7:0] exp_tx[$];

  serial_hba_bridge #(
    .CLK_FREQUENCY(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .hba_clk(hba_clk), .hba_reset(hba_reset), .rxd(rxd), .rts(rts),
    .txd(txd), .cts(cts), .intr(intr),
    .hba_mgrant(hba_mgrant), .hba_xferack(hba_xferack), .hba_dbus(hba_dbus),
    .masterx_request(masterx_request), .master_abus(master_abus),
    .master_rnw(master_rnw), .master_dbus(master_dbus)
  );

  always #5 hba_clk = ~hba_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (DIV) @(negedge hba_clk);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 6000) begin
      @(negedge hba_clk);
      n++;
    end
    repeat (30) @(negedge hba_clk);
    check({tag, "_tx_left"}, exp_tx.size(), 0);
    check({tag, "_bus_left"}, exp_bus.size(), 0);
  endtask

  // HBA slave: grants after grant_dly cycles, acks in the same cycle unless hang is set.
  initial begin
    bus_t e;
    int   cnt;
    hba_mgrant = 1'b0; hba_xferack = 1'b0; hba_dbus = '0;
    forever begin
      @(negedge hba_clk);
      if (masterx_request === 1'b1) begin
        for (int i = 0; i < grant_dly; i++) begin
          check("pre_grant_abus", master_abus, 0);
          check("bus_wait_cts", cts, 0);
          @(negedge hba_clk);
        end
        hba_mgrant = 1'b1;
        #1;
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", exp_bus.size(), 1);
        end else begin
          e = exp_bus.pop_front();
          check("bus_rnw", master_rnw, e.rnw);
          check("bus_abus", master_abus, e.abus);
          if (!e.rnw) check("bus_dbus", master_dbus, e.dbus);
        end
        if (hang != 0) begin
          cnt = 0;
          while (masterx_request === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge hba_clk);
          end
          check("tmo_req_cycles", cnt, 16);
          check("tmo_intr_set", intr, 1);
          check("tmo_abus_zero", master_abus, 0);
        end else begin
          hba_xferack = 1'b1;
          if (e.rnw) hba_dbus = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
          @(negedge hba_clk);
          check("post_ack_req", masterx_request, 0);
          check("post_ack_abus", master_abus, 0);
          check("post_ack_rnw", master_rnw, 0);
          check("post_ack_dbus", master_dbus, 0);
        end
        hba_mgrant = 1'b0; hba_xferack = 1'b0; hba_dbus = '0;
      end
    end
  end

  // TX monitor: decodes txd mid-bit and compares against the expected reply queue.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge hba_clk);
      if (txd === 1'b0) begin
        check("tx_start_rts", rts, 1);
        repeat (DIV / 2) @(negedge hba_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge hba_clk);
          b[i] = txd;
        end
        repeat (DIV) @(negedge hba_clk);
        check("tx_stop_bit", txd, 1);
        tx_count++;
        if (exp_tx.size() == 0) check("tx_unexpected", exp_tx.size(), 1);
        else                    check("tx_byte", b, exp_tx.pop_front());
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, low;
    hba_reset = 1'b1; rxd = 1'b1; rts = 1'b1;
    repeat (3) @(posedge hba_clk);
    @(negedge hba_clk);
    hba_reset = 1'b0;
    #1;
    check("rst_cts_low", cts, 0);
    check("rst_txd", txd, 1);
    check("rst_intr", intr, 0);
    check("rst_req", masterx_request, 0);
    check("rst_abus", master_abus, 0);
    check("rst_rnw", master_rnw, 0);
    check("rst_dbus", master_dbus, 0);
    @(negedge hba_clk);
    check("rst_cts_high", cts, 1);

    // single write
    exp_bus.push_back('{1'b0, 12'h310, 8'h5A});
    exp_tx.push_back(8'h06);
    send_byte(8'h03); send_byte(8'h10); send_byte(8'h5A);
    drain("single_write");

    // burst read with register wrap
    exp_bus.push_back('{1'b1, 12'h2FE, 8'h00});
    exp_bus.push_back('{1'b1, 12'h2FF, 8'h00});
    exp_bus.push_back('{1'b1, 12'h200, 8'h00});
    exp_bus.push_back('{1'b1, 12'h201, 8'h00});
    foreach (exp_bus[i]) rd_q.push_back(8'h11 * (i + 1));
    foreach (exp_bus[i]) exp_tx.push_back(8'h11 * (i + 1));
    send_byte(8'hB2); send_byte(8'hFE);
    drain("burst_read");

    // flow control: reply held while rts = 0
    rts = 1'b0;
    exp_bus.push_back('{1'b1, 12'h005, 8'h00});
    rd_q.push_back(8'h77);
    exp_tx.push_back(8'h77);
    snap = tx_count;
    send_byte(8'h80); send_byte(8'h05);
    for (int n = 0; n < 2000 && exp_bus.size() != 0; n++) @(negedge hba_clk);
    low = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge hba_clk);
      if (txd !== 1'b1) low++;
    end
    check("flow_txd_idle", low, 0);
    rts = 1'b1;
    drain("flow");
    check("flow_one_byte", tx_count - snap, 1);

    // delayed grant
    grant_dly = 5;
    exp_bus.push_back('{1'b0, 12'h421, 8'hC3});
    exp_tx.push_back(8'h06);
    send_byte(8'h04); send_byte(8'h21); send_byte(8'hC3);
    drain("hygiene");
    grant_dly = 1;

    // reset after CMD of a 3-transfer write discards the frame
    send_byte(8'h25);
    repeat (4) @(negedge hba_clk);
    hba_reset = 1'b1;
    @(negedge hba_clk);
    hba_reset = 1'b0;
    repeat (4) @(negedge hba_clk);
    check("midrst_req", masterx_request, 0);
    check("midrst_cts", cts, 1);
    exp_bus.push_back('{1'b0, 12'h100, 8'hAA});
    exp_tx.push_back(8'h06);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    drain("after_reset");

`ifdef SERIAL_HBA_TIMEOUT_EN
    // watchdog on a 2-transfer write
    hang = 1; grant_dly = 0;
    exp_bus.push_back('{1'b0, 12'h307, 8'h55});
    exp_tx.push_back(8'hEE);
    send_byte(8'h13); send_byte(8'h07); send_byte(8'h55); send_byte(8'h66);
    drain("timeout");
    check("tmo_intr_sticky", intr, 1);
    hang = 0; grant_dly = 1;
    exp_bus.push_back('{1'b1, 12'h000, 8'h00});
    rd_q.push_back(8'h12);
    exp_tx.push_back(8'h12);
    send_byte(8'h80);
    check("tmo_intr_cleared", intr, 0);
    send_byte(8'h00);
    drain("post_timeout");
`endif

    check("final_intr", intr, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
